modn_updown_counter: RTL and testbench

- Parametrised successor to the fixed mod-5 D-flip-flop counter.
- Synchronous modulo-N binary counter with count enable, up/down direction, synchronous parallel load, and a terminal-count output for cascading.
- Used as the generic sequencer/divider primitive in the sequential-design blocks.
- Replaces hand-derived next-state equations with a parametrised next-state function.

---
 rtl/modn_updown_counter.sv | 113 +++++++++++
 tb/tb_modn_updown_counter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/modn_updown_counter.sv
// Modulo-MODULUS up/down counter with parallel load, terminal count and optional Gray output.
// Optional feature macro: COUNTER_GRAY_OUT_EN (registered Gray-coded copy of the count).
module modn_updown_counter #(
   parameter int WIDTH   = 3,
   parameter int MODULUS = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] out,
   output logic             tc,
   output logic [WIDTH-1:0] gray_out
);

   // Arithmetic is one bit wider so MODULUS == 2**WIDTH compares cleanly.
   localparam logic [WIDTH:0] MAX_V  = (WIDTH+1)'(MODULUS - 1);
   localparam logic [WIDTH:0] ONE_V  = (WIDTH+1)'(1);
   localparam logic [WIDTH:0] ZERO_V = (WIDTH+1)'(0);

   generate
      if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
         $error("modn_updown_counter: WIDTH must be in 1..16");
      end
      if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
         $error("modn_updown_counter: MODULUS must be in 2..2**WIDTH");
      end
   endgenerate

   logic [WIDTH-1:0] out_r;
   logic [WIDTH:0]   cnt_ext_s;
   logic [WIDTH:0]   load_ext_s;
   logic [WIDTH-1:0] next_s;

   assign cnt_ext_s  = {1'b0, out_r};
   assign load_ext_s = {1'b0, load_val};
   assign out        = out_r;

   // Next count: load (clamped) over count over hold; illegal states recover to 0.
   always_comb begin
      next_s = out_r;
      if (load) begin
         if (load_ext_s > MAX_V) begin
            next_s = WIDTH'(MAX_V);
         end else begin
            next_s = load_val;
         end
      end else if (en) begin
         if (cnt_ext_s > MAX_V) begin
            next_s = WIDTH'(ZERO_V);
         end else if (up_dn) begin
            if (cnt_ext_s == MAX_V) begin
               next_s = WIDTH'(ZERO_V);
            end else begin
               next_s = WIDTH'(cnt_ext_s + ONE_V);
            end
         end else begin
            if (cnt_ext_s == ZERO_V) begin
               next_s = WIDTH'(MAX_V);
            end else begin
               next_s = WIDTH'(cnt_ext_s - ONE_V);
            end
         end
      end else begin
         next_s = out_r;
      end
   end

   // Terminal count: high in the cycle before a wrap, so a cascaded stage can use it as en.
   always_comb begin
      tc = 1'b0;
      if (rst || load || !en) begin
         tc = 1'b0;
      end else if (up_dn) begin
         tc = (cnt_ext_s == MAX_V);
      end else begin
         tc = (cnt_ext_s == ZERO_V);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_r <= '0;
      end else begin
         out_r <= next_s;
      end
   end

`ifdef COUNTER_GRAY_OUT_EN
   logic [WIDTH-1:0] gray_r;

   function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] v);
      return v ^ (v >> 1'b1);
   endfunction

   // Gray register is fed from next_s so it tracks out with no extra latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         gray_r <= '0;
      end else begin
         gray_r <= to_gray(next_s);
      end
   end

   assign gray_out = gray_r;
`else
   assign gray_out = '0;
`endif

endmodule

// File: tb/tb_modn_updown_counter.sv
// Directed bench: mod-5 counter (WIDTH=3) and full-range mod-16 counter (WIDTH=4).
module tb_modn_updown_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, en_a, up_a, ld_a, tc_a;
   logic [2:0] lv_a, out_a, gray_a;
   logic       rst_b, en_b, up_b, ld_b, tc_b;
   logic [3:0] lv_b, out_b, gray_b;

   int n_cmp = 0;
   int n_err = 0;

   modn_updown_counter #(.WIDTH(3), .MODULUS(5)) dut_a (
      .clk(clk), .rst(rst_a), .en(en_a), .up_dn(up_a), .load(ld_a),
      .load_val(lv_a), .out(out_a), .tc(tc_a), .gray_out(gray_a)
   );

   modn_updown_counter #(.WIDTH(4), .MODULUS(16)) dut_b (
      .clk(clk), .rst(rst_b), .en(en_b), .up_dn(up_b), .load(ld_b),
      .load_val(lv_b), .out(out_b), .tc(tc_b), .gray_out(gray_b)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected gray_out for a given count in the current build.
   function automatic logic [15:0] gx(input logic [15:0] v);
`ifdef COUNTER_GRAY_OUT_EN
      return v ^ (v >> 1);
`else
      return 16'd0;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_a(input string tag, input int exp);
      chk({tag, "_out"}, 16'(out_a), 16'(exp));
      chk({tag, "_gray"}, 16'(gray_a), gx(16'(exp)));
   endtask

   int exp_up[8] = '{0, 1, 2, 3, 4, 0, 1, 2};
   int exp_dn[5] = '{2, 1, 0, 4, 3};
   int exp_tg[4] = '{3, 2, 3, 2};
   logic [3:0] prev_g;

   initial begin
      rst_a = 1'b1; en_a = 1'b1; up_a = 1'b1; ld_a = 1'b0; lv_a = 3'd0;
      rst_b = 1'b1; en_b = 1'b1; up_b = 1'b1; ld_b = 1'b0; lv_b = 4'd0;

      // Reset held two cycles with en=1
      #1;
      chk("rst_tc_pre", 16'(tc_a), 16'd0);
      tick();
      tick();
      chk_a("rst", 0);
      chk("rst_tc", 16'(tc_a), 16'd0);

      // Up count 0..4 wrap
      rst_a = 1'b0;
      for (int i = 0; i < 7; i++) begin
         #1;
         chk("up_tc", 16'(tc_a), (exp_up[i] == 4) ? 16'd1 : 16'd0);
         tick();
         chk_a("up", exp_up[i + 1]);
      end

      // Down count 2,1,0,4,3
      up_a = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("dn_tc", 16'(tc_a), (exp_dn[i] == 0) ? 16'd1 : 16'd0);
         tick();
         chk_a("dn", exp_dn[i + 1]);
      end

      // Loads: en/up_dn ignored, clamp above MODULUS-1
      ld_a = 1'b1; lv_a = 3'd1;
      tick();
      chk_a("ld1", 1);
      lv_a = 3'd3;
      #1;
      chk("ld3_tc", 16'(tc_a), 16'd0);
      tick();
      chk_a("ld3", 3);
      up_a = 1'b1; lv_a = 3'd7;
      tick();
      chk_a("ld7_clamp", 4);
      lv_a = 3'd5;
      #1;
      chk("ld5_tc_at_max", 16'(tc_a), 16'd0);
      tick();
      chk_a("ld5_clamp", 4);
      lv_a = 3'd2;
      tick();
      chk_a("ld2", 2);

      // Reset beats load
      rst_a = 1'b1; lv_a = 3'd3;
      #1;
      chk("rstld_tc", 16'(tc_a), 16'd0);
      tick();
      chk_a("rst_ld", 0);
      rst_a = 1'b0; lv_a = 3'd2; en_a = 1'b0;
      tick();
      chk_a("ld2b", 2);

      // Hold for 3 cycles
      ld_a = 1'b0; up_a = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("hold_tc", 16'(tc_a), 16'd0);
         tick();
         chk_a("hold", 2);
      end

      // Direction toggled every cycle
      en_a = 1'b1;
      for (int i = 0; i < 4; i++) begin
         up_a = (i % 2 == 0) ? 1'b1 : 1'b0;
         tick();
         chk_a("toggle", exp_tg[i]);
      end

      // Reset mid-count
      rst_a = 1'b1;
      tick();
      chk_a("rst_mid", 0);
      rst_a = 1'b0;

      // Full-range counter: 17 up steps through the 15->0 wrap
      chk("b_rst_out", 16'(out_b), 16'd0);
      chk("b_rst_gray", 16'(gray_b), 16'd0);
      rst_b = 1'b0;
      prev_g = 4'd0;
      for (int i = 0; i < 17; i++) begin
         #1;
         chk("b_up_tc", 16'(tc_b), ((i % 16) == 15) ? 16'd1 : 16'd0);
         tick();
         chk("b_up_out", 16'(out_b), 16'((i + 1) % 16));
         chk("b_up_gray", 16'(gray_b), gx(16'((i + 1) % 16)));
`ifdef COUNTER_GRAY_OUT_EN
         chk("b_gray_1bit", 16'($countones(gray_b ^ prev_g)), 16'd1);
         if (((i + 1) % 16) == 15) begin
            chk("b_gray_15", 16'(gray_b), 16'b1000);
         end
`endif
         prev_g = gray_b;
      end

      // Down across 0 -> 15
      up_b = 1'b0;
      tick();
      chk("b_dn_out0", 16'(out_b), 16'd0);
      #1;
      chk("b_dn_tc", 16'(tc_b), 16'd1);
      tick();
      chk("b_dn_wrap", 16'(out_b), 16'd15);
      chk("b_dn_gray", 16'(gray_b), gx(16'd15));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
